// File: rtl/seq_bin_to_bcd.sv
// seq_bin_to_bcd: iterative double-dabble binary-to-BCD converter.
// Captures an unsigned magnitude plus sign on start, performs one
// add-3/shift iteration per clock, then publishes a registered packed-BCD
// result together with the captured sign and pulses done for one cycle.
//
// Handshake: start is sampled only while idle (busy=0); it is ignored while
// busy. done is a single-cycle pulse, and bcd_out/sign_out are already
// valid in that cycle and then hold until the next completed conversion.
module seq_bin_to_bcd #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 5   // 10**DIGITS must exceed 2**BIN_W - 1
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  sign_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [BCD_W-1:0]   bcd_acc_q, bcd_acc_d;
    logic [BIN_W-1:0]   bin_acc_q, bin_acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_acc_q, sign_acc_d;
    logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
    logic               sign_out_q, sign_out_d;
    logic [BCD_W-1:0]   bcd_adj;

    // Add 3 to every digit that is 5 or more, all digits in parallel, so the
    // following left shift carries correctly into the next decimal digit.
    always_comb begin
        bcd_adj = bcd_acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_acc_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state and datapath control for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_d    = state_q;
        bcd_acc_d  = bcd_acc_q;
        bin_acc_d  = bin_acc_q;
        cnt_d      = cnt_q;
        sign_acc_d = sign_acc_q;
        bcd_out_d  = bcd_out_q;
        sign_out_d = sign_out_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    bcd_acc_d  = '0;
                    bin_acc_d  = bin_in;
                    sign_acc_d = sign_in;
                    cnt_d      = CNT_W'(BIN_W);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // {bcd, bin} shifts left as one register after the adjust.
                bcd_acc_d = {bcd_adj[BCD_W-2:0], bin_acc_q[BIN_W-1]};
                bin_acc_d = {bin_acc_q[BIN_W-2:0], 1'b0};
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Final iteration: publish the shifted result on this edge.
                    bcd_out_d  = {bcd_adj[BCD_W-2:0], bin_acc_q[BIN_W-1]};
                    sign_out_d = sign_acc_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, accumulators and result registers; reset aborts any conversion.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bcd_acc_q  <= '0;
            bin_acc_q  <= '0;
            cnt_q      <= '0;
            sign_acc_q <= 1'b0;
            bcd_out_q  <= '0;
            sign_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcd_acc_q  <= bcd_acc_d;
            bin_acc_q  <= bin_acc_d;
            cnt_q      <= cnt_d;
            sign_acc_q <= sign_acc_d;
            bcd_out_q  <= bcd_out_d;
            sign_out_q <= sign_out_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign bcd_out  = bcd_out_q;
    assign sign_out = sign_out_q;

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Testbench for seq_bin_to_bcd: directed scenarios plus random conversions
// checked against a decimal-arithmetic reference model.
module tb_seq_bin_to_bcd;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 5;
    localparam int BCD_W  = 4 * DIGITS;

    logic               sys_clk = 1'b0;
    logic               rst_n   = 1'b0;
    logic               start   = 1'b0;
    logic [BIN_W-1:0]   bin_in  = '0;
    logic               sign_in = 1'b0;
    logic               busy;
    logic               done;
    logic [BCD_W-1:0]   bcd_out;
    logic               sign_out;

    int checks   = 0;
    int failures = 0;

    // Expected held result (model state between conversions).
    logic [BCD_W-1:0] hold_bcd  = '0;
    logic             hold_sign = 1'b0;

    seq_bin_to_bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .sign_in  (sign_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .sign_out (sign_out)
    );

    // Clock
    always #5 sys_clk = ~sys_clk;

    // Reference: decimal digits by repeated division.
    function automatic logic [BCD_W-1:0] ref_bcd(input int unsigned v);
        logic [BCD_W-1:0] r;
        int unsigned      x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // One full conversion from idle; checks latency, busy/done widths, result.
    task automatic convert(input int unsigned v, input logic s, input string tag);
        int done_k;
        int done_cnt;
        int busy_cnt;
        done_k   = -1;
        done_cnt = 0;
        busy_cnt = 0;
        start   = 1'b1;
        bin_in  = v[BIN_W-1:0];
        sign_in = s;
        tick();                     // start sampled at E0
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (k == 13) check({tag, "_hold_before_done"}, 32'(bcd_out), 32'(hold_bcd));
            if (k == 14) begin
                hold_bcd  = ref_bcd(v);
                hold_sign = s;
                check({tag, "_bcd"}, 32'(bcd_out), 32'(hold_bcd));
                check({tag, "_sign"}, 32'(sign_out), 32'(hold_sign));
            end
            tick();
        end
        check({tag, "_latency"}, 32'(done_k), 32'd14);
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd15);
    endtask

    initial begin
        int             done_cnt;
        int             n;
        int             done_ks[3];
        int unsigned    vals[3];
        logic           digits_ok;

        // Reset state (asynchronous: checked before any clock edge).
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd", 32'(bcd_out), 32'd0);
        check("reset_sign", 32'(sign_out), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Directed conversions.
        convert(0, 1'b0, "zero");
        convert(1234, 1'b1, "v1234");
        convert(16383, 1'b0, "max");
        digits_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_out[4*i +: 4] > 4'd9) digits_ok = 1'b0;
        end
        check("max_digits_le9", 32'(digits_ok), 32'd1);

        // Start re-asserted mid-conversion must be ignored.
        start = 1'b1; bin_in = 14'd99; sign_in = 1'b0;
        tick();
        start = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (k == 5) begin
                start = 1'b1; bin_in = 14'd5000;
            end else begin
                start = 1'b0;
            end
            if (done) done_cnt++;
            tick();
        end
        start = 1'b0;
        hold_bcd = ref_bcd(99);
        check("restart_ignored_pulses", 32'(done_cnt), 32'd1);
        check("restart_ignored_bcd", 32'(bcd_out), 32'(hold_bcd));
        convert(5000, 1'b0, "v5000");

        // Reset in the middle of a conversion.
        convert(777, 1'b1, "v777");
        start = 1'b1; bin_in = 14'd42; sign_in = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        rst_n = 1'b0;
        #1;
        hold_bcd  = '0;
        hold_sign = 1'b0;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_bcd", 32'(bcd_out), 32'd0);
        check("midreset_sign", 32'(sign_out), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) done_cnt++;
            tick();
        end
        check("midreset_no_done", 32'(done_cnt), 32'd0);
        check("midreset_bcd_after", 32'(bcd_out), 32'd0);

        // Start held high: back-to-back conversions every BIN_W+2 cycles.
        vals = '{10, 255, 8191};
        done_ks = '{-1, -1, -1};
        n = 0;
        start = 1'b1; bin_in = vals[0][BIN_W-1:0]; sign_in = 1'b0;
        tick();
        for (int k = 0; k < 52; k++) begin
            if (done && n < 3) begin
                done_ks[n] = k;
                check("held_start_bcd", 32'(bcd_out), 32'(ref_bcd(vals[n])));
                n++;
                if (n < 3) bin_in = vals[n][BIN_W-1:0];
                else start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        hold_bcd = ref_bcd(8191);
        check("held_start_count", 32'(n), 32'd3);
        check("held_start_done0", 32'(done_ks[0]), 32'd14);
        check("held_start_done1", 32'(done_ks[1]), 32'd30);
        check("held_start_done2", 32'(done_ks[2]), 32'd46);
        for (int k = 0; k < 4; k++) tick();

        // Random conversions against the model.
        for (int r = 0; r < 16; r++) begin
            convert($urandom_range(0, (1 << BIN_W) - 1), 1'($urandom_range(0, 1)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
